// File: rtl/spk_out_buf.sv
// spk_out_buf: spike output stage between the neuron soma and the router.
// Captures the {z,y,x} source ID of every firing neuron and attaches a
// destination ID (source plus a per-axis offset, each axis wrapping on its
// own). The {dst,src} packet is buffered in a FIFO and sent to the router
// over a valid/ready handshake. Back-pressure goes to the work controller
// through an almost-full flag.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   soma_spk_vld             neuron fired this cycle
//   config_spk_out_neuid     {z,y,x} source ID of the firing neuron
//   config_clear             synchronous flush of FIFO and status
//   dst_dx/dst_dy/dst_dz     per-axis destination offsets
//   spk_out_config_full      almost-full back-pressure (registered)
//   spk_out_vld/_data/_rdy   router handshake, packet {dst_z,dst_y,dst_x,src_z,src_y,src_x}
//   spk_out_ovf              sticky overflow flag
//   spk_out_drop_cnt         saturating count of dropped spikes
module spk_out_buf #(
  parameter int SW     = 24,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soma_spk_vld,
  input  logic [SW-1:0]     config_spk_out_neuid,
  input  logic              config_clear,
  input  logic [SW/3-1:0]   dst_dx,
  input  logic [SW/3-1:0]   dst_dy,
  input  logic [SW/3-1:0]   dst_dz,
  output logic              spk_out_config_full,
  output logic              spk_out_vld,
  output logic [2*SW-1:0]   spk_out_data,
  input  logic              spk_out_rdy,
  output logic              spk_out_ovf,
  output logic [7:0]        spk_out_drop_cnt
);

  localparam int FW = SW / 3;
  localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH - MARGIN);

  logic [2*SW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            out_vld_q, out_vld_d;
  logic [2*SW-1:0] out_data_q, out_data_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;

  logic            pop_s, wr_acc_s, drop_s, load_s, stor_empty_s, mem_we_s;
  logic [AW:0]     stor_cnt_s;
  logic [FW-1:0]   dst_x_s, dst_y_s, dst_z_s;
  logic [2*SW-1:0] wr_pkt_s;

  // Packet assembly: each axis adds its offset modulo 2^FW, no carry between axes.
  always_comb begin
    dst_x_s  = config_spk_out_neuid[FW-1:0]      + dst_dx;
    dst_y_s  = config_spk_out_neuid[2*FW-1:FW]   + dst_dy;
    dst_z_s  = config_spk_out_neuid[3*FW-1:2*FW] + dst_dz;
    wr_pkt_s = {dst_z_s, dst_y_s, dst_x_s, config_spk_out_neuid};
  end

  // Handshake qualifiers. count includes the output register, so storage
  // occupancy is count minus the output-register valid bit.
  always_comb begin
    pop_s        = out_vld_q & spk_out_rdy;
    stor_cnt_s   = count_q - {{AW{1'b0}}, out_vld_q};
    stor_empty_s = (stor_cnt_s == {(AW+1){1'b0}});
    // At full, a pop in the same cycle frees the slot the write needs.
    wr_acc_s     = soma_spk_vld & ~config_clear & ((count_q != CNT_MAX) | pop_s);
    drop_s       = soma_spk_vld & ~config_clear & (count_q == CNT_MAX) & ~pop_s;
    load_s       = ~out_vld_q | pop_s;
  end

  // Next-state logic for pointers, count, output register and status.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    mem_we_s   = 1'b0;
    if (config_clear) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {(AW+1){1'b0}};
      out_vld_d  = 1'b0;
      out_data_d = {(2*SW){1'b0}};
      ovf_d      = 1'b0;
      drop_d     = 8'd0;
    end else begin
      count_d = count_q + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, pop_s};
      if (load_s) begin
        if (!stor_empty_s) begin
          // Head of storage moves into the output register; a new write queues behind it.
          out_vld_d  = 1'b1;
          out_data_d = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          mem_we_s   = wr_acc_s;
        end else if (wr_acc_s) begin
          // Storage empty: bypass straight into the output register.
          out_vld_d  = 1'b1;
          out_data_d = wr_pkt_s;
        end else begin
          out_vld_d  = 1'b0;
        end
      end else begin
        mem_we_s = wr_acc_s;
      end
      if (mem_we_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end else begin
          drop_d = drop_q;
        end
      end else begin
        ovf_d = ovf_q;
      end
    end
    full_d = (count_d >= CNT_FULL);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      out_vld_q  <= 1'b0;
      out_data_q <= {(2*SW){1'b0}};
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wr_pkt_s;
    end
  end

  assign spk_out_vld         = out_vld_q;
  assign spk_out_data        = out_data_q;
  assign spk_out_config_full = full_q;
  assign spk_out_ovf         = ovf_q;
  assign spk_out_drop_cnt    = drop_q;

endmodule

// File: tb/tb_spk_out_buf.sv
// Testbench for spk_out_buf: table of single-spike vectors plus directed
// back-pressure, drain, clear and reset sequences, all checked against a
// packet queue and an occupancy model kept by the bench.
module tb_spk_out_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        soma_spk_vld;
  logic [23:0] config_spk_out_neuid;
  logic        config_clear;
  logic [7:0]  dst_dx, dst_dy, dst_dz;
  logic        spk_out_config_full;
  logic        spk_out_vld;
  logic [47:0] spk_out_data;
  logic        spk_out_rdy;
  logic        spk_out_ovf;
  logic [7:0]  spk_out_drop_cnt;

  spk_out_buf dut (
    .clk                  (clk),
    .rst                  (rst),
    .soma_spk_vld         (soma_spk_vld),
    .config_spk_out_neuid (config_spk_out_neuid),
    .config_clear         (config_clear),
    .dst_dx               (dst_dx),
    .dst_dy               (dst_dy),
    .dst_dz               (dst_dz),
    .spk_out_config_full  (spk_out_config_full),
    .spk_out_vld          (spk_out_vld),
    .spk_out_data         (spk_out_data),
    .spk_out_rdy          (spk_out_rdy),
    .spk_out_ovf          (spk_out_ovf),
    .spk_out_drop_cnt     (spk_out_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench model
  logic [47:0] q[$];
  int          mcount = 0;
  logic        movf   = 1'b0;
  int          mdrop  = 0;
  logic        mfull  = 1'b0;

  typedef struct {
    logic [23:0] neuid;
    logic [7:0]  dx, dy, dz;
    logic [47:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] exp_pkt(input logic [23:0] id, input logic [7:0] dx,
                                          input logic [7:0] dy, input logic [7:0] dz);
    logic [7:0] x, y, z;
    x = id[7:0] + dx;
    y = id[15:8] + dy;
    z = id[23:16] + dz;
    return {z, y, x, id};
  endfunction

  // Check outputs against the model, advance the model for this cycle's inputs, clock once.
  task automatic tick();
    logic pop_m, acc_m;
    chk("vld", {63'd0, spk_out_vld}, {63'd0, (mcount > 0)});
    if (q.size() > 0) chk("data", {16'd0, spk_out_data}, {16'd0, q[0]});
    chk("full", {63'd0, spk_out_config_full}, {63'd0, mfull});
    chk("ovf", {63'd0, spk_out_ovf}, {63'd0, movf});
    chk("drop_cnt", {56'd0, spk_out_drop_cnt}, 64'(mdrop));
    pop_m = (mcount > 0) && spk_out_rdy;
    if (config_clear) begin
      q.delete();
      mcount = 0;
      movf   = 1'b0;
      mdrop  = 0;
    end else begin
      acc_m = soma_spk_vld && ((mcount < 16) || pop_m);
      if (pop_m) begin
        void'(q.pop_front());
        mcount--;
      end
      if (acc_m) begin
        q.push_back(exp_pkt(config_spk_out_neuid, dst_dx, dst_dy, dst_dz));
        mcount++;
      end else if (soma_spk_vld) begin
        movf = 1'b1;
        if (mdrop < 255) mdrop++;
      end
    end
    mfull = (mcount >= 12);
    @(posedge clk);
    #1;
  endtask

  vec_t tv[4];
  logic [47:0] held;

  initial begin
    rst = 1'b1; soma_spk_vld = 1'b0; config_spk_out_neuid = 24'd0; config_clear = 1'b0;
    dst_dx = 8'd0; dst_dy = 8'd0; dst_dz = 8'd0; spk_out_rdy = 1'b0;
    #3;
    chk("rst_vld", {63'd0, spk_out_vld}, 64'd0);
    chk("rst_data", {16'd0, spk_out_data}, 64'd0);
    chk("rst_full", {63'd0, spk_out_config_full}, 64'd0);
    chk("rst_ovf", {63'd0, spk_out_ovf}, 64'd0);
    chk("rst_drop", {56'd0, spk_out_drop_cnt}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single spikes: table of hand-computed packets
    tv[0] = '{24'h000203, 8'h01, 8'h00, 8'h05, 48'h050204_000203};
    tv[1] = '{24'h1234FF, 8'h02, 8'h00, 8'h00, 48'h123401_1234FF};
    tv[2] = '{24'hFFFFFF, 8'h01, 8'h01, 8'h01, 48'h000000_FFFFFF};
    tv[3] = '{24'h80407F, 8'h80, 8'hC0, 8'h81, 48'h0100FF_80407F};
    spk_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      soma_spk_vld = 1'b1;
      config_spk_out_neuid = tv[i].neuid;
      dst_dx = tv[i].dx; dst_dy = tv[i].dy; dst_dz = tv[i].dz;
      tick();
      soma_spk_vld = 1'b0;
      chk("tbl_vld", {63'd0, spk_out_vld}, 64'd1);
      chk("tbl_data", {16'd0, spk_out_data}, {16'd0, tv[i].exp});
      tick();
      chk("tbl_idle", {63'd0, spk_out_vld}, 64'd0);
    end

    // Back-pressure: spike every cycle with rdy low
    spk_out_rdy = 1'b0;
    dst_dx = 8'h03; dst_dy = 8'h10; dst_dz = 8'hF0;
    for (int i = 1; i <= 17; i++) begin
      soma_spk_vld = 1'b1;
      config_spk_out_neuid = 24'(i * 24'h010101);
      tick();
      if (i == 1) held = spk_out_data;
      if (i == 11) chk("bp_full_11", {63'd0, spk_out_config_full}, 64'd0);
      if (i == 12) chk("bp_full_12", {63'd0, spk_out_config_full}, 64'd1);
      chk("bp_stable", {16'd0, spk_out_data}, {16'd0, held});
    end
    chk("bp_ovf", {63'd0, spk_out_ovf}, 64'd1);
    chk("bp_drop", {56'd0, spk_out_drop_cnt}, 64'd1);

    // Simultaneous write and pop at full: no drop
    spk_out_rdy = 1'b1;
    config_spk_out_neuid = 24'hABCDEF;
    tick();
    soma_spk_vld = 1'b0;
    chk("simul_drop", {56'd0, spk_out_drop_cnt}, 64'd1);
    chk("simul_full", {63'd0, spk_out_config_full}, 64'd1);

    // Drain: 16 packets in order, full checked each cycle by tick
    for (int i = 0; i < 16; i++) tick();
    chk("drain_empty", {63'd0, spk_out_vld}, 64'd0);

    // Clear with a concurrent write
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      soma_spk_vld = 1'b1;
      config_spk_out_neuid = 24'(24'h300000 + i);
      tick();
    end
    config_clear = 1'b1;
    config_spk_out_neuid = 24'h777777;
    tick();
    config_clear = 1'b0;
    soma_spk_vld = 1'b0;
    chk("clr_vld", {63'd0, spk_out_vld}, 64'd0);
    chk("clr_ovf", {63'd0, spk_out_ovf}, 64'd0);
    chk("clr_drop", {56'd0, spk_out_drop_cnt}, 64'd0);
    tick();
    chk("clr_lost", {63'd0, spk_out_vld}, 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      soma_spk_vld = 1'($urandom_range(0, 1));
      spk_out_rdy = ($urandom_range(0, 3) != 0);
      config_spk_out_neuid = 24'($urandom);
      dst_dx = 8'($urandom); dst_dy = 8'($urandom); dst_dz = 8'($urandom);
      tick();
    end

    // Reset mid-stream
    spk_out_rdy = 1'b0;
    soma_spk_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      config_spk_out_neuid = 24'(24'h500000 + i);
      tick();
    end
    soma_spk_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_vld", {63'd0, spk_out_vld}, 64'd0);
    chk("mrst_data", {16'd0, spk_out_data}, 64'd0);
    chk("mrst_full", {63'd0, spk_out_config_full}, 64'd0);
    q.delete(); mcount = 0; movf = 1'b0; mdrop = 0; mfull = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    spk_out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
